// File: rtl/contador_pkg.sv
// Shared constants and sequence helpers for the ring/Johnson shift counter.
package contador_pkg;

    localparam logic MODO_ANEL    = 1'b0;
    localparam logic MODO_JOHNSON = 1'b1;

    // Widest register the helpers handle; callers pass their real width as n.
    localparam int MAX_N = 64;

    typedef logic [MAX_N-1:0] vetor_t;

    // Seed of the sequence: one-hot bit 0 for ring, all zeros for Johnson.
    function automatic vetor_t semente(input logic modo);
        vetor_t s;
        s = '0;
        if (modo == MODO_ANEL) begin
            s[0] = 1'b1;
        end
        return s;
    endfunction

    // Ring is legal with exactly one bit set.
    // Johnson is legal with at most one boundary between neighbouring bits.
    function automatic logic legal(input vetor_t q, input logic modo, input int n);
        int cnt;
        cnt = 0;
        if (modo == MODO_ANEL) begin
            for (int i = 0; i < MAX_N; i++) begin
                if (i < n && q[i]) begin
                    cnt++;
                end
            end
            return (cnt == 1);
        end
        for (int i = 0; i < MAX_N - 1; i++) begin
            if (i < n - 1 && q[i] != q[i+1]) begin
                cnt++;
            end
        end
        return (cnt <= 1);
    endfunction

    // Position of q in its sequence; illegal states report position 0.
    // Johnson: the fill phase has q[0]=1 (p ones = position p); the drain
    // phase has q[0]=0 and counts down from 2n, so position = 2n - p.
    function automatic int unsigned calc_indice(input vetor_t q, input logic modo, input int n);
        int unsigned p;
        p = 0;
        if (!legal(q, modo, n)) begin
            return 0;
        end
        if (modo == MODO_ANEL) begin
            for (int i = 0; i < MAX_N; i++) begin
                if (i < n && q[i]) begin
                    p = unsigned'(i);
                end
            end
            return p;
        end
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && q[i]) begin
                p++;
            end
        end
        if (q[0] || p == 0) begin
            return p;
        end
        return unsigned'(2 * n) - p;
    endfunction

endpackage

// File: rtl/contador_deslocamento_param_indice.sv
// Combinational decoder: legality and sequence position of an N-bit pattern.
module indice_deslocamento
    import contador_pkg::*;
#(
    parameter int N  = 6,
    parameter int IW = $clog2(2*N)
) (
    input  logic [N-1:0]  q,
    input  logic          modo,
    output logic          legal,
    output logic [IW-1:0] indice
);

    vetor_t q_ext;

    // Widen to the helper width, then decode legality and position.
    always_comb begin
        q_ext  = vetor_t'(q);
        legal  = contador_pkg::legal(q_ext, modo, N);
        indice = IW'(calc_indice(q_ext, modo, N));
    end

endmodule

// File: rtl/contador_deslocamento_param.sv
// N-bit shift counter, ring or Johnson selectable at run time, with up/down
// stepping, checked parallel load, self-correction and a wrap pulse.
module contador_deslocamento_param
    import contador_pkg::*;
#(
    parameter int N  = 6,
    parameter int IW = $clog2(2*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          habilitar,
    input  logic          modo,
    input  logic          direcao,
    input  logic          carregar,
    input  logic [N-1:0]  valor_carga,
    output logic [N-1:0]  saida_q,
    output logic [IW-1:0] indice,
    output logic          fim_ciclo,
    output logic          erro_carga,
    output logic          estado_invalido
);

    logic [N-1:0]  estado_q;
    logic          modo_reg;
    logic          fim_q;
    logic          erro_q;

    logic          legal_atual;
    logic [IW-1:0] indice_atual;
    logic          legal_carga;
    logic [IW-1:0] indice_carga_unused;

    logic [N-1:0]  semente_n;
    logic [N-1:0]  passo_frente;
    logic [N-1:0]  passo_tras;
    logic [IW-1:0] ultimo;

    // Decoder for the live state.
    indice_deslocamento #(.N(N), .IW(IW)) u_indice_atual (
        .q      (estado_q),
        .modo   (modo),
        .legal  (legal_atual),
        .indice (indice_atual)
    );

    // Decoder used only to judge whether a load value is legal.
    indice_deslocamento #(.N(N), .IW(IW)) u_indice_carga (
        .q      (valor_carga),
        .modo   (modo),
        .legal  (legal_carga),
        .indice (indice_carga_unused)
    );

    // Seed, both step candidates and the last sequence position for the active mode.
    always_comb begin
        semente_n = N'(semente(modo));
        if (modo_reg == MODO_JOHNSON) begin
            passo_frente = {estado_q[N-2:0], ~estado_q[N-1]};
            passo_tras   = {~estado_q[0], estado_q[N-1:1]};
            ultimo       = IW'(2*N - 1);
        end else begin
            passo_frente = {estado_q[N-2:0], estado_q[N-1]};
            passo_tras   = {estado_q[0], estado_q[N-1:1]};
            ultimo       = IW'(N - 1);
        end
    end

    // State register: reset > mode change > illegal reseed > load > step > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= semente_n;
            modo_reg <= modo;
            fim_q    <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            fim_q  <= 1'b0;
            erro_q <= 1'b0;
            if (modo != modo_reg) begin
                estado_q <= semente_n;
                modo_reg <= modo;
            end else if (!legal_atual) begin
                estado_q <= semente_n;
            end else if (carregar) begin
                if (legal_carga) begin
                    estado_q <= valor_carga;
                end else begin
                    estado_q <= semente_n;
                    erro_q   <= 1'b1;
                end
            end else if (habilitar) begin
                if (direcao) begin
                    estado_q <= passo_tras;
                    fim_q    <= (indice_atual == '0);
                end else begin
                    estado_q <= passo_frente;
                    fim_q    <= (indice_atual == ultimo);
                end
            end
        end
    end

    // Outputs are the registered state and its combinational decode.
    always_comb begin
        saida_q         = estado_q;
        indice          = indice_atual;
        fim_ciclo       = fim_q;
        erro_carga      = erro_q;
        estado_invalido = ~legal_atual;
    end

endmodule
